// File: rtl/uc_multicycle.sv
// uc_multicycle: multi-cycle control sequencer for the RV32I datapath.
// Walks every instruction through FETCH/DECODE/EXEC/MEM/WB so that a single
// memory port and a single ALU serve the whole instruction.
module uc_multicycle (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] selector,
  input  logic       Negative,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWriteEn,
  output logic       Branch,
  output logic       Jump,
  output logic       PCSrc,
  output logic       LUIOP,
  output logic       WDSrc,
  output logic       ALUSrc,
  output logic       ALUOP,
  output logic       Mem2Reg,
  output logic [1:0] ImmSel,
  output logic [2:0] state,
  output logic       retire,
  output logic       illegal
);

  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_I      = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_LUI    = 5'b01101;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXEC    = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    ILLEGAL = 3'd5
  } state_t;

  state_t     cur_state;
  logic [4:0] op;
  logic       illegal_q;

  function automatic logic is_supported(input logic [4:0] s);
    return (s == OP_R) || (s == OP_I) || (s == OP_LOAD) || (s == OP_STORE) ||
           (s == OP_BRANCH) || (s == OP_JAL) || (s == OP_LUI);
  endfunction

  // Sequencer: advances the phase, captures the opcode in DECODE, and traps unsupported opcodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= FETCH;
      op        <= 5'd0;
      illegal_q <= 1'b0;
    end else begin
      case (cur_state)
        FETCH: begin
          if (mem_ready) cur_state <= DECODE;
        end
        DECODE: begin
          op <= selector;
          if (is_supported(selector)) begin
            cur_state <= EXEC;
          end else begin
            cur_state <= ILLEGAL;
            illegal_q <= 1'b1;
          end
        end
        EXEC: begin
          if ((op == OP_LOAD) || (op == OP_STORE)) cur_state <= MEM;
          else if (op == OP_BRANCH)                cur_state <= FETCH;
          else                                     cur_state <= WB;
        end
        MEM: begin
          if (mem_ready) cur_state <= (op == OP_STORE) ? FETCH : WB;
        end
        WB:      cur_state <= FETCH;
        ILLEGAL: cur_state <= ILLEGAL;
        default: cur_state <= FETCH;
      endcase
    end
  end

  // Control bundle decode: Mealy on mem_ready/Negative, and held at zero while reset is asserted.
  always_comb begin
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWriteEn = 1'b0;
    Branch     = 1'b0;
    Jump       = 1'b0;
    PCSrc      = 1'b0;
    LUIOP      = 1'b0;
    WDSrc      = 1'b0;
    ALUSrc     = 1'b0;
    ALUOP      = 1'b0;
    Mem2Reg    = 1'b0;
    ImmSel     = 2'b00;
    retire     = 1'b0;
    if (rst_n) begin
      case (cur_state)
        FETCH: begin
          MemRead = 1'b1;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
          end
        end
        EXEC: begin
          ALUSrc = (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_LUI);
          ALUOP  = (op == OP_R) || (op == OP_I);
          LUIOP  = (op == OP_LUI);
          case (op)
            OP_STORE: ImmSel = 2'b01;
            OP_BRANCH: begin
              ImmSel  = 2'b10;
              Branch  = 1'b1;
              PCSrc   = Negative;
              PCWrite = Negative;
              retire  = 1'b1;
            end
            OP_JAL: begin
              ImmSel  = 2'b11;
              Jump    = 1'b1;
              PCSrc   = 1'b1;
              PCWrite = 1'b1;
            end
            default: ImmSel = 2'b00;
          endcase
        end
        MEM: begin
          if (op == OP_STORE) begin
            MemWrite = 1'b1;
            retire   = mem_ready;
          end else begin
            MemRead = 1'b1;
          end
        end
        WB: begin
          RegWriteEn = 1'b1;
          Mem2Reg    = (op == OP_LOAD);
          WDSrc      = (op == OP_JAL);
          retire     = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign state   = cur_state;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_uc_multicycle.sv
// tb_uc_multicycle: randomized scoreboard bench for the multi-cycle sequencer.
// Each instruction is summarized as per-instruction strobe counts; the
// stimulus side predicts them, the monitor accumulates them up to retire.
module tb_uc_multicycle;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] selector;
  logic       Negative;
  logic       mem_ready;
  logic       IRWrite, PCWrite, MemRead, MemWrite, RegWriteEn;
  logic       Branch, Jump, PCSrc, LUIOP, WDSrc, ALUSrc, ALUOP, Mem2Reg;
  logic [1:0] ImmSel;
  logic [2:0] state;
  logic       retire, illegal;

  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_I      = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_LUI    = 5'b01101;

  typedef struct {
    logic [4:0] op;
    int cycles, memRead, memWrite, irWrite, pcWrite, pcSrc, regWrite;
    int branch, jump, aluSrc, aluOp, luiOp, mem2Reg, wdSrc, immOr, overlap;
  } rec_t;

  rec_t sbQueue[$];
  rec_t acc;
  int   compared   = 0;
  int   mismatched = 0;

  logic [4:0] opList [7];
  logic [14:0] outBundle;

  assign outBundle = {IRWrite, PCWrite, MemRead, MemWrite, RegWriteEn, Branch, Jump,
                      PCSrc, LUIOP, WDSrc, ALUSrc, ALUOP, Mem2Reg, ImmSel, retire};

  uc_multicycle dut (
    .clk(clk), .rst_n(rst_n), .selector(selector), .Negative(Negative),
    .mem_ready(mem_ready), .IRWrite(IRWrite), .PCWrite(PCWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWriteEn(RegWriteEn), .Branch(Branch), .Jump(Jump),
    .PCSrc(PCSrc), .LUIOP(LUIOP), .WDSrc(WDSrc), .ALUSrc(ALUSrc), .ALUOP(ALUOP),
    .Mem2Reg(Mem2Reg), .ImmSel(ImmSel), .state(state), .retire(retire), .illegal(illegal)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Behavioural model: what one instruction should look like in aggregate.
  function automatic rec_t modelInstr(input logic [4:0] op, input int fw, input int mw, input logic neg);
    rec_t r;
    bit isMem = (op == OP_LOAD) || (op == OP_STORE);
    r = '{default: 0};
    r.op       = op;
    r.cycles   = fw + ((op == OP_BRANCH) ? 3 : (op == OP_LOAD) ? 5 + mw : (op == OP_STORE) ? 4 + mw : 4);
    r.memRead  = fw + 1 + ((op == OP_LOAD) ? mw + 1 : 0);
    r.memWrite = (op == OP_STORE) ? mw + 1 : 0;
    r.irWrite  = 1;
    r.pcWrite  = 1 + ((op == OP_BRANCH && neg) ? 1 : 0) + ((op == OP_JAL) ? 1 : 0);
    r.pcSrc    = ((op == OP_BRANCH && neg) ? 1 : 0) + ((op == OP_JAL) ? 1 : 0);
    r.regWrite = (op == OP_BRANCH || op == OP_STORE) ? 0 : 1;
    r.branch   = (op == OP_BRANCH) ? 1 : 0;
    r.jump     = (op == OP_JAL) ? 1 : 0;
    r.aluSrc   = (op == OP_I || isMem || op == OP_LUI) ? 1 : 0;
    r.aluOp    = (op == OP_R || op == OP_I) ? 1 : 0;
    r.luiOp    = (op == OP_LUI) ? 1 : 0;
    r.mem2Reg  = (op == OP_LOAD) ? 1 : 0;
    r.wdSrc    = (op == OP_JAL) ? 1 : 0;
    r.immOr    = (op == OP_STORE) ? 1 : (op == OP_BRANCH) ? 2 : (op == OP_JAL) ? 3 : 0;
    r.overlap  = 0;
    return r;
  endfunction

  // Drives one instruction: fw fetch wait cycles, mw memory wait cycles, neg for the EXEC cycle.
  task automatic applyStimulus(input logic [4:0] op, input int fw, input int mw, input logic neg);
    rec_t r;
    int   memStart;
    r = modelInstr(op, fw, mw, neg);
    sbQueue.push_back(r);
    memStart = fw + 3;
    for (int c = 0; c < r.cycles; c++) begin
      selector  = (c == fw + 1) ? op : 5'($urandom);
      Negative  = (c == fw + 2) ? neg : 1'($urandom);
      if (c < fw)             mem_ready = 1'b0;
      else if (c == fw)       mem_ready = 1'b1;
      else if ((op == OP_LOAD || op == OP_STORE) && c >= memStart && c < memStart + mw)
                              mem_ready = 1'b0;
      else if ((op == OP_LOAD || op == OP_STORE) && c == memStart + mw)
                              mem_ready = 1'b1;
      else                    mem_ready = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic compareRecord(input rec_t e, input rec_t a);
    string p;
    p = $sformatf("op%b", e.op);
    checkOutput({p, "_cycles"},   a.cycles,   e.cycles);
    checkOutput({p, "_MemRead"},  a.memRead,  e.memRead);
    checkOutput({p, "_MemWrite"}, a.memWrite, e.memWrite);
    checkOutput({p, "_IRWrite"},  a.irWrite,  e.irWrite);
    checkOutput({p, "_PCWrite"},  a.pcWrite,  e.pcWrite);
    checkOutput({p, "_PCSrc"},    a.pcSrc,    e.pcSrc);
    checkOutput({p, "_RegWrite"}, a.regWrite, e.regWrite);
    checkOutput({p, "_Branch"},   a.branch,   e.branch);
    checkOutput({p, "_Jump"},     a.jump,     e.jump);
    checkOutput({p, "_ALUSrc"},   a.aluSrc,   e.aluSrc);
    checkOutput({p, "_ALUOP"},    a.aluOp,    e.aluOp);
    checkOutput({p, "_LUIOP"},    a.luiOp,    e.luiOp);
    checkOutput({p, "_Mem2Reg"},  a.mem2Reg,  e.mem2Reg);
    checkOutput({p, "_WDSrc"},    a.wdSrc,    e.wdSrc);
    checkOutput({p, "_ImmSel"},   a.immOr,    e.immOr);
    checkOutput({p, "_retireWithIR"}, a.overlap, e.overlap);
  endtask

  // Monitor: accumulate strobes each cycle, and on retire pop the prediction and compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      acc = '{default: 0};
    end else begin
      acc.cycles++;
      acc.memRead  += int'(MemRead);
      acc.memWrite += int'(MemWrite);
      acc.irWrite  += int'(IRWrite);
      acc.pcWrite  += int'(PCWrite);
      acc.pcSrc    += int'(PCSrc);
      acc.regWrite += int'(RegWriteEn);
      acc.branch   += int'(Branch);
      acc.jump     += int'(Jump);
      acc.aluSrc   += int'(ALUSrc);
      acc.aluOp    += int'(ALUOP);
      acc.luiOp    += int'(LUIOP);
      acc.mem2Reg  += int'(Mem2Reg);
      acc.wdSrc    += int'(WDSrc);
      acc.immOr    |= int'(ImmSel);
      acc.overlap  += int'(retire & IRWrite);
      if (retire) begin
        if (sbQueue.size() == 0) begin
          checkOutput("unexpected_retire", 1, 0);
        end else begin
          compareRecord(sbQueue.pop_front(), acc);
        end
        acc = '{default: 0};
      end
    end
  end

  initial begin
    opList = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI};
    rst_n     = 1'b0;
    selector  = 5'b11111;
    Negative  = 1'b1;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state",   int'(state),     0);
    checkOutput("reset_illegal", int'(illegal),   0);
    checkOutput("reset_outputs", int'(outBundle), 0);
    rst_n = 1'b1;
    #1;
    checkOutput("release_MemRead", int'(MemRead), 1);

    applyStimulus(OP_R, 0, 0, 1'b0);
    applyStimulus(OP_LOAD, 2, 3, 1'b0);
    applyStimulus(OP_STORE, 0, 0, 1'b0);
    applyStimulus(OP_BRANCH, 0, 0, 1'b1);
    applyStimulus(OP_BRANCH, 0, 0, 1'b0);
    applyStimulus(OP_JAL, 0, 0, 1'b0);
    applyStimulus(OP_LUI, 0, 0, 1'b0);
    applyStimulus(OP_I, 1, 0, 1'b1);
    for (int n = 0; n < 40; n++) begin
      applyStimulus(opList[$urandom_range(0, 6)], $urandom_range(0, 3),
                    $urandom_range(0, 3), 1'($urandom));
    end
    checkOutput("pending_after_random", sbQueue.size(), 0);

    // Unsupported opcode: trap in ILLEGAL with everything quiet.
    mem_ready = 1'b1;
    selector  = 5'($urandom);
    @(posedge clk); #1;
    selector = 5'b11111;
    @(posedge clk); #1;
    for (int c = 0; c < 6; c++) begin
      selector  = 5'($urandom);
      Negative  = 1'($urandom);
      mem_ready = 1'($urandom);
      #2;
      checkOutput("illegal_state",   int'(state),     5);
      checkOutput("illegal_flag",    int'(illegal),   1);
      checkOutput("illegal_outputs", int'(outBundle), 0);
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("illegal_reset_state", int'(state),   0);
    checkOutput("illegal_reset_flag",  int'(illegal), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // STORE aborted by a reset pulse while waiting in MEM.
    for (int c = 0; c < 5; c++) begin
      selector  = (c == 1) ? OP_STORE : 5'($urandom);
      mem_ready = (c == 0) ? 1'b1 : (c >= 3) ? 1'b0 : 1'($urandom);
      Negative  = 1'($urandom);
      if (c < 4) begin
        @(posedge clk); #1;
      end
    end
    #2;
    checkOutput("abort_in_mem_MemWrite", int'(MemWrite), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_state",   int'(state),     0);
    checkOutput("abort_illegal", int'(illegal),   0);
    checkOutput("abort_outputs", int'(outBundle), 0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #2;
    checkOutput("abort_release_state",    int'(state),    0);
    checkOutput("abort_release_MemRead",  int'(MemRead),  1);
    checkOutput("abort_release_MemWrite", int'(MemWrite), 0);
    applyStimulus(OP_R, 1, 0, 1'b0);
    applyStimulus(OP_STORE, 0, 2, 1'b0);
    checkOutput("pending_at_end", sbQueue.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
